pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ISSUE_WIDTH, default 2, meaning PCs per fetch group; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning PC width in bits.
REQ-003 SHALL have parameter RESET_PC, default 32'h1c000000, meaning boot address; must be aligned to ISSUE_WIDTH*4.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port stall, input, 1, meaning hold the current fetch group.
REQ-007 SHALL have port branch_flag_i, input, 1, meaning branch redirect request.
REQ-008 SHALL have port branch_target_address, input, ADDR_WIDTH, meaning branch target.
REQ-009 SHALL have port flush, input, 1, meaning exception/ertn redirect request.
REQ-010 SHALL have port new_pc, input, ADDR_WIDTH, meaning flush target.
REQ-011 SHALL have port ready_i, input, 1, meaning the fetch unit accepts the current group.
REQ-012 SHALL have port valid_o, output, 1, meaning pc_o holds a live fetch request.
REQ-013 SHALL have port pc_o, output, ISSUE_WIDTH*ADDR_WIDTH, meaning lane i PC in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-014 SHALL have port pc_valid_o, output, ISSUE_WIDTH, meaning per-lane valid mask.
REQ-015 SHALL have port adef_o, output, 1, meaning misaligned redirect target error.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (valid_o=0) and RUN (valid_o=1).
REQ-017 SHALL move from IDLE to RUN on the first clock edge with rst low; RUN persists until rst.
REQ-018 SHALL hold a group base register aligned to G=ISSUE_WIDTH*4 bytes; lane i PC = base + 4*i.
REQ-019 SHALL apply next-group priority flush > stall > branch > advance > hold.
REQ-020 SHALL, on flush: load base = new_pc aligned down to G, and set pc_valid_o[i] = (i >= new_pc offset/4); ready_i and stall are ignored.
REQ-021 SHALL, on branch_flag_i with stall low: load base and mask from branch_target_address by the same rule as REQ-020; ready_i is ignored.
REQ-022 SHALL advance base by G with pc_valid_o all ones only when in RUN, valid_o=1, ready_i=1, and no higher-priority event is present.
REQ-023 SHALL otherwise hold base and mask unchanged (stall high, or ready_i low).
REQ-024 SHALL make each redirect visible on pc_o at the next edge (1-cycle latency); a redirect cancels any unaccepted group.
REQ-025 SHALL compute additions modulo 2^ADDR_WIDTH; base all-ones-minus-(G-1) wraps to 0.
REQ-026 SHALL accept flush or branch in IDLE; the redirect is loaded and appears when RUN is entered.
REQ-027 SHALL keep adef_o low in all cases unless the feature of REQ-032 is compiled in.

Reset
REQ-028 SHALL, on rst high at an edge, set state to IDLE, valid_o to 0, base to RESET_PC, pc_valid_o to all ones, and adef_o to 0.
REQ-029 SHALL let rst override flush, branch, and stall in the same cycle.
REQ-030 SHALL, when rst is asserted mid-operation, discard the outstanding group; valid_o drops at that edge.

Configuration
REQ-031 SHALL use the macro PC_GEN_ALIGN_CHK_EN.
REQ-032 SHALL, with PC_GEN_ALIGN_CHK_EN defined, check each accepted redirect target: if target[1:0] != 0, set adef_o=1 and pc_valid_o=0 for that group; adef_o is cleared by the next redirect with an aligned target, or by rst; advance is blocked while adef_o=1.
REQ-033 SHALL, without PC_GEN_ALIGN_CHK_EN, tie adef_o to 0 and silently ignore target[1:0].

Verification (ISSUE_WIDTH=2)
REQ-034 SHALL cover: rst for 2 cycles, then release -> one IDLE cycle with valid_o=0, then valid_o=1, pc_o={1c000004,1c000000}, mask 2'b11.
REQ-035 SHALL cover: ready_i=1 for 3 cycles from 1c000000 -> bases 1c000008, 1c000010, 1c000018; ready_i=0 -> base held.
REQ-036 SHALL cover: branch to 1c000104 -> base 1c000100, mask 2'b10; next accept -> 1c000108, mask 2'b11.
REQ-037 SHALL cover: stall=1 with branch to 1c000200 -> base unchanged; stall=1 with flush new_pc=1c008000 -> base 1c008000, mask 2'b11.
REQ-038 SHALL cover: base FFFFFFF8 accepted -> base 00000000, pc_o={00000004,00000000}.
REQ-039 SHALL cover, with PC_GEN_ALIGN_CHK_EN: branch to 1c000102 -> adef_o=1, mask 2'b00, advance blocked; flush to 1c001000 -> adef_o=0, mask 2'b11.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-group PC generator: aligned group base, per-lane valid mask, redirect priority.
// Optional misaligned-target detection compiled in with PC_GEN_ALIGN_CHK_EN.
module pc_gen #(
    parameter int                    ISSUE_WIDTH = 2,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h1c000000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              stall,
    input  logic                              branch_flag_i,
    input  logic [ADDR_WIDTH-1:0]             branch_target_address,
    input  logic                              flush,
    input  logic [ADDR_WIDTH-1:0]             new_pc,
    input  logic                              ready_i,
    output logic                              valid_o,
    output logic [ISSUE_WIDTH*ADDR_WIDTH-1:0] pc_o,
    output logic [ISSUE_WIDTH-1:0]            pc_valid_o,
    output logic                              adef_o
);

    localparam int                    G          = ISSUE_WIDTH * 4;
    localparam int                    OFF_W      = $clog2(G);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(G - 1));

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   base_p0;
    logic [ISSUE_WIDTH-1:0]  mask_p0;
    logic                    adef_p0;

    logic                    redirect;
    logic [ADDR_WIDTH-1:0]   redir_tgt;
    logic                    misalign;
    logic                    advance;

    // Lanes before the target's slot inside the group are not fetched.
    function automatic logic [ISSUE_WIDTH-1:0] lane_mask(input logic [ADDR_WIDTH-1:0] t);
        logic [ISSUE_WIDTH-1:0] m;
        int start;
        start = int'(32'(t[OFF_W-1:0]) >> 2);
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            m[i] = (i >= start);
        end
        return m;
    endfunction

    always_comb begin
        redirect  = flush | (branch_flag_i & ~stall);
        redir_tgt = flush ? new_pc : branch_target_address;
`ifdef PC_GEN_ALIGN_CHK_EN
        misalign  = |redir_tgt[1:0];
`else
        misalign  = 1'b0;
`endif
        advance   = (state == RUN) & valid_o & ready_i & ~stall & ~adef_p0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid_o <= 1'b0;
            base_p0 <= RESET_PC;
            mask_p0 <= '1;
            adef_p0 <= 1'b0;
        end else begin
            state   <= RUN;
            valid_o <= 1'b1;
            if (redirect) begin
                base_p0 <= redir_tgt & ALIGN_MASK;
                mask_p0 <= misalign ? '0 : lane_mask(redir_tgt);
                adef_p0 <= misalign;
            end else if (advance) begin
                base_p0 <= base_p0 + ADDR_WIDTH'(G);
                mask_p0 <= '1;
            end
        end
    end

    always_comb begin
        pc_o = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            pc_o[i*ADDR_WIDTH +: ADDR_WIDTH] = base_p0 + ADDR_WIDTH'(4 * i);
        end
    end

    assign pc_valid_o = mask_p0;
    assign adef_o     = adef_p0;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with ISSUE_WIDTH=2: vector table plus a redirect/hold sequence.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst, stall, branch_flag_i, flush, ready_i;
    logic [31:0] branch_target_address, new_pc;
    logic        valid_o, adef_o;
    logic [63:0] pc_o;
    logic [1:0]  pc_valid_o;

    int checks = 0;
    int errors = 0;

    pc_gen #(.ISSUE_WIDTH(2), .ADDR_WIDTH(32), .RESET_PC(32'h1c000000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_flag_i(branch_flag_i),
        .branch_target_address(branch_target_address), .flush(flush), .new_pc(new_pc),
        .ready_i(ready_i), .valid_o(valid_o), .pc_o(pc_o), .pc_valid_o(pc_valid_o),
        .adef_o(adef_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, br;
        logic [31:0] bta;
        logic        fl;
        logic [31:0] npc;
        logic        rdy;
        logic        ev;
        logic [31:0] eb;
        logic [1:0]  em;
        logic        ea;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    task automatic check(input string name, input logic ev, input logic [31:0] eb,
                         input logic [1:0] em, input logic ea);
        logic [63:0] epc;
        epc = {eb + 32'd4, eb};
        checks += 4;
        if (valid_o !== ev) begin
            errors++;
            $display("FAIL %s valid_o got %0b want %0b", name, valid_o, ev);
        end
        if (pc_o !== epc) begin
            errors++;
            $display("FAIL %s pc_o got %h want %h", name, pc_o, epc);
        end
        if (pc_valid_o !== em) begin
            errors++;
            $display("FAIL %s pc_valid_o got %b want %b", name, pc_valid_o, em);
        end
        if (adef_o !== ea) begin
            errors++;
            $display("FAIL %s adef_o got %0b want %0b", name, adef_o, ea);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] bt,
                         input logic f, input logic [31:0] np, input logic rd);
        rst = r; stall = s; branch_flag_i = b; branch_target_address = bt;
        flush = f; new_pc = np; ready_i = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          rst stall br  bta           fl  npc           rdy  ev  base          mask  adef
        vecs[0]  = '{1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h1c000000, 2'b11, 0};
        vecs[1]  = '{1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h1c000000, 2'b11, 0};
        vecs[2]  = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h1c000000, 2'b11, 0};
        vecs[3]  = '{0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h1c000008, 2'b11, 0};
        vecs[4]  = '{0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h1c000010, 2'b11, 0};
        vecs[5]  = '{0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h1c000018, 2'b11, 0};
        vecs[6]  = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h1c000018, 2'b11, 0};
        vecs[7]  = '{0, 0, 1, 32'h1c000104, 0, 32'h0,        0, 1, 32'h1c000100, 2'b10, 0};
        vecs[8]  = '{0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h1c000108, 2'b11, 0};
        vecs[9]  = '{0, 1, 1, 32'h1c000200, 0, 32'h0,        1, 1, 32'h1c000108, 2'b11, 0};
        vecs[10] = '{0, 1, 0, 32'h0,        1, 32'h1c008000, 1, 1, 32'h1c008000, 2'b11, 0};
        vecs[11] = '{0, 0, 1, 32'h1c000200, 1, 32'h1c00800c, 1, 1, 32'h1c008008, 2'b10, 0};
        vecs[12] = '{0, 1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h1c008008, 2'b10, 0};
        vecs[13] = '{0, 0, 0, 32'h0,        1, 32'hfffffff8, 0, 1, 32'hfffffff8, 2'b11, 0};
        vecs[14] = '{0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h00000000, 2'b11, 0};
`ifdef PC_GEN_ALIGN_CHK_EN
        vecs[15] = '{0, 0, 1, 32'h1c000106, 0, 32'h0,        0, 1, 32'h1c000100, 2'b00, 1};
`else
        vecs[15] = '{0, 0, 1, 32'h1c000106, 0, 32'h0,        0, 1, 32'h1c000100, 2'b10, 0};
`endif
        vecs[16] = '{1, 1, 1, 32'h1c000200, 1, 32'h1c008000, 1, 0, 32'h1c000000, 2'b11, 0};
        vecs[17] = '{0, 0, 0, 32'h0,        1, 32'h1c000004, 0, 1, 32'h1c000000, 2'b10, 0};
        vecs[18] = '{0, 0, 1, 32'h1c000010, 0, 32'h0,        0, 1, 32'h1c000010, 2'b11, 0};

        rst = 1'b1; stall = 1'b0; branch_flag_i = 1'b0; flush = 1'b0; ready_i = 1'b0;
        branch_target_address = '0; new_pc = '0;
        @(negedge clk);

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].rst, vecs[k].stall, vecs[k].br, vecs[k].bta,
                  vecs[k].fl, vecs[k].npc, vecs[k].rdy);
            check($sformatf("vec%0d", k), vecs[k].ev, vecs[k].eb, vecs[k].em, vecs[k].ea);
        end

        // Misaligned redirect, accept attempts, then recovery by an aligned flush.
        drive(0, 0, 1, 32'h1c000102, 0, 32'h0, 1);
`ifdef PC_GEN_ALIGN_CHK_EN
        check("adef_set", 1, 32'h1c000100, 2'b00, 1);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
        check("adef_block1", 1, 32'h1c000100, 2'b00, 1);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
        check("adef_block2", 1, 32'h1c000100, 2'b00, 1);
`else
        check("mis_ignored", 1, 32'h1c000100, 2'b11, 0);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
        check("mis_adv1", 1, 32'h1c000108, 2'b11, 0);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
        check("mis_adv2", 1, 32'h1c000110, 2'b11, 0);
`endif
        drive(0, 0, 0, 32'h0, 1, 32'h1c001000, 0);
        check("flush_clear", 1, 32'h1c001000, 2'b11, 0);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
        check("post_clear_adv", 1, 32'h1c001008, 2'b11, 0);

        // Reset mid-operation drops valid at that edge.
        drive(1, 0, 0, 32'h0, 0, 32'h0, 1);
        check("mid_rst", 0, 32'h1c000000, 2'b11, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
